// File: rtl/integral_image_builder_if.sv
// Pixel-stream and cache-write handshake bundle for integral_image_builder.
// The master modport is the builder side, the slave modport is the environment side.
interface integral_image_builder_if #(
  parameter int PIXEL_BITS = 8,
  parameter int WORD_SIZE  = 32,
  parameter int WORDS      = 4,
  parameter int ADDR_WIDTH = 17
);
  logic                        pix_valid;
  logic                        pix_ready;
  logic [PIXEL_BITS-1:0]       pix_data;
  logic                        wr_en;
  logic                        wr_ready;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [WORDS*WORD_SIZE-1:0]  wr_data;

  modport master (
    input  pix_valid, pix_data, wr_ready,
    output pix_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output pix_valid, pix_data, wr_ready,
    input  pix_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/integral_image_builder.sv
// Streams a raster frame into blocked integral-image cache writes (zero top row, zero left column).
// Optional sticky protocol-error flag: define INTEGRAL_BUILDER_ERR_EN to add err_sticky.
module integral_image_builder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIXEL_BITS = 8,
  parameter int WORD_SIZE  = 32,
  parameter int WORDS      = 4,
  parameter int BLOCKS     = (IMG_WIDTH + WORDS) / WORDS,
  parameter int ADDR_WIDTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  output logic busy,
  output logic frame_done,
`ifdef INTEGRAL_BUILDER_ERR_EN
  output logic err_sticky,
`endif
  integral_image_builder_if.master bus
);

  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 2);
  localparam int LW = $clog2(WORDS);
  localparam int DW = WORDS * WORD_SIZE;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ZERO_ROW = 2'd1,
    S_ROW      = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [WORD_SIZE-1:0]   rs_q, rs_d;
  logic                   first_row_q, first_row_d;
  logic [DW-1:0]          asm_q, asm_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DW-1:0]          wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]  addr_cnt_q, addr_cnt_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;

  // Previous integral row; never cleared, first_row_q masks stale contents.
  logic [WORD_SIZE-1:0]   prev_mem [IMG_WIDTH+1];

  logic                   wr_acc;
  logic                   out_free;
  logic                   pix_acc;
  logic                   emit;
  logic [WORD_SIZE-1:0]   rs_sum;
  logic [WORD_SIZE-1:0]   ii_val;

  // Next-state, datapath and output-register computation.
  always_comb begin
    wr_acc   = wr_en_q && bus.wr_ready;
    out_free = !wr_en_q || bus.wr_ready;
    pix_acc  = (state_q == S_ROW) && out_free && bus.pix_valid;
    rs_sum   = rs_q + WORD_SIZE'(bus.pix_data);
    ii_val   = first_row_q ? rs_sum : (rs_sum + prev_mem[x_q]);
    emit     = pix_acc && ((lane_q == LW'(WORDS - 1)) || (x_q == XW'(IMG_WIDTH)));

    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    lane_d       = lane_q;
    rs_d         = rs_q;
    first_row_d  = first_row_q;
    asm_d        = asm_q;
    wr_en_d      = wr_en_q && !bus.wr_ready;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    addr_cnt_d   = addr_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d     = S_ZERO_ROW;
          x_d         = '0;
          y_d         = '0;
          lane_d      = '0;
          rs_d        = '0;
          first_row_d = 1'b1;
          asm_d       = '0;
          addr_cnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ZERO_ROW: begin
        if (wr_acc && (wr_addr_q == ADDR_WIDTH'(BLOCKS - 1))) begin
          state_d = S_ROW;
          x_d     = XW'(1);
          y_d     = YW'(1);
          lane_d  = LW'(1);
          asm_d   = '0;
        end else if (out_free && (addr_cnt_q < ADDR_WIDTH'(BLOCKS))) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = addr_cnt_q;
          wr_data_d  = '0;
          addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
        end else begin
          state_d = S_ZERO_ROW;
        end
      end
      S_ROW: begin
        if (pix_acc) begin
          asm_d[int'(lane_q)*WORD_SIZE +: WORD_SIZE] = ii_val;
          if (emit) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_cnt_q;
            wr_data_d  = asm_d;
            addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
            asm_d      = '0;
          end else begin
            wr_en_d = wr_en_q && !bus.wr_ready;
          end
          if (x_q == XW'(IMG_WIDTH)) begin
            rs_d        = '0;
            first_row_d = 1'b0;
            x_d         = XW'(1);
            lane_d      = LW'(1);
            y_d         = y_q + YW'(1);
            state_d     = (y_q == YW'(IMG_HEIGHT)) ? S_DONE : S_ROW;
          end else begin
            rs_d   = rs_sum;
            x_d    = x_q + XW'(1);
            lane_d = (lane_q == LW'(WORDS - 1)) ? LW'(0) : (lane_q + LW'(1));
          end
        end else begin
          state_d = S_ROW;
        end
      end
      S_DONE: begin
        if (wr_acc) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        wr_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      lane_q       <= '0;
      rs_q         <= '0;
      first_row_q  <= 1'b0;
      asm_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      addr_cnt_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      lane_q       <= lane_d;
      rs_q         <= rs_d;
      first_row_q  <= first_row_d;
      asm_q        <= asm_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      addr_cnt_q   <= addr_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer update, read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      prev_mem[x_q] <= ii_val;
    end
  end

`ifdef INTEGRAL_BUILDER_ERR_EN
  logic err_q, err_d;

  // Sticky flag for a restart while busy or pixels offered while idle.
  always_comb begin
    err_d = err_q || (frame_start && busy_q) || (bus.pix_valid && (state_q == S_IDLE));
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif

  assign bus.pix_ready = (state_q == S_ROW) && (!wr_en_q || bus.wr_ready);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_integral_image_builder.sv
// Self-checking bench for integral_image_builder: directed and random frames
// compared against a summed-area reference computed straight from the pixels.
module tb_integral_image_builder;
  localparam int W      = 4;
  localparam int H      = 2;
  localparam int WORDS  = 2;
  localparam int BLOCKS = 3;
  localparam int PB     = 8;
  localparam int WS     = 16;
  localparam int AW     = 4;
  localparam int NW     = (H + 1) * BLOCKS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic busy;
  logic frame_done;
`ifdef INTEGRAL_BUILDER_ERR_EN
  logic err_sticky;
`endif

  integral_image_builder_if #(.PIXEL_BITS(PB), .WORD_SIZE(WS), .WORDS(WORDS), .ADDR_WIDTH(AW)) bus ();

  integral_image_builder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(PB), .WORD_SIZE(WS),
    .WORDS(WORDS), .BLOCKS(BLOCKS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_start(frame_start),
    .busy(busy),
    .frame_done(frame_done),
`ifdef INTEGRAL_BUILDER_ERR_EN
    .err_sticky(err_sticky),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int fd_cyc = 0;
  int fd_cnt = 0;
  logic fd_busy = 1'b1;
  logic [AW-1:0] got_addr [$];
  logic [WORDS*WS-1:0] got_data [$];
  int pacc [$];

  int pix [1:H][1:W];
  int stall_mode = 0;
  int stall_cnt = 0;
  bit rand_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted writes, accepted pixels and frame_done timing.
  always @(negedge clk) begin
    if (bus.wr_en && bus.wr_ready) begin
      got_addr.push_back(bus.wr_addr);
      got_data.push_back(bus.wr_data);
      last_acc_cyc <= cyc;
    end
    if (bus.pix_valid && bus.pix_ready) pacc.push_back(cyc);
    if (frame_done) begin
      fd_cyc  <= cyc;
      fd_busy <= busy;
      fd_cnt  <= fd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (stall_mode == 1) begin
      if (stall_cnt == 0 && bus.wr_en && bus.wr_addr == AW'(4)) begin
        bus.wr_ready = 1'b0;
        stall_cnt = 1;
        #1;
        chk("stall_data", bus.wr_data, 64'h0003_0002);
        chk("stall_pix_ready", bus.pix_ready, 64'd0);
      end else if (stall_cnt > 0 && stall_cnt < 5) begin
        bus.wr_ready = 1'b0;
        stall_cnt++;
        #1;
        chk("stall_wr_en", bus.wr_en, 64'd1);
        chk("stall_addr", bus.wr_addr, 64'd4);
        chk("stall_data", bus.wr_data, 64'h0003_0002);
        chk("stall_pix_ready", bus.pix_ready, 64'd0);
      end else begin
        bus.wr_ready = 1'b1;
      end
    end else if (stall_mode == 2) begin
      bus.wr_ready = ($urandom_range(0, 2) != 0);
    end else begin
      bus.wr_ready = 1'b1;
    end
  endtask

  task automatic fill(input int mode, input int val);
    for (int y = 1; y <= H; y++)
      for (int x = 1; x <= W; x++)
        pix[y][x] = (mode == 0) ? val : (mode == 1) ? ((y - 1) * W + x) : int'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input int abort_at, input bit mid_start);
    int k;
    int guard;
    int fdb;
    bit sent;
    k = 0;
    guard = 0;
    sent = 1'b0;
    fdb = fd_cnt;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    while (k < W * H && k != abort_at && guard < 1000) begin
      bus.pix_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pix_data  = PB'(pix[k / W + 1][k % W + 1]);
      frame_start   = mid_start && !sent && (k == 5);
      if (frame_start) sent = 1'b1;
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) k++;
      step();
      guard++;
    end
    bus.pix_valid = 1'b0;
    frame_start = 1'b0;
    if (abort_at < 0) begin
      chk("pixels_consumed", k, W * H);
      guard = 0;
      while (fd_cnt == fdb && guard < 200) begin
        step();
        guard++;
      end
      chk("frame_done_seen", fd_cnt - fdb, 64'd1);
    end
  endtask

  task automatic check_frame(input int base, input string tag);
    int ii [0:H][0:W];
    int y;
    int b;
    int col;
    logic [WORDS*WS-1:0] exp;
    for (int yy = 0; yy <= H; yy++)
      for (int xx = 0; xx <= W; xx++) begin
        ii[yy][xx] = 0;
        for (int j = 1; j <= yy; j++)
          for (int i = 1; i <= xx; i++)
            ii[yy][xx] += pix[j][i];
      end
    chk({tag, "_count"}, got_addr.size() - base, NW);
    for (int n = 0; n < NW; n++) begin
      if (base + n < got_addr.size()) begin
        y = n / BLOCKS;
        b = n % BLOCKS;
        exp = '0;
        for (int l = 0; l < WORDS; l++) begin
          col = b * WORDS + l;
          if (col <= W) exp[l*WS +: WS] = WS'(ii[y][col]);
        end
        chk({tag, "_addr"}, got_addr[base + n], n);
        chk({tag, "_data"}, got_data[base + n], exp);
      end
    end
  endtask

  initial begin
    int base;
    int pbase;
    int fdb;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.wr_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", bus.pix_ready, 64'd0);
    chk("rst_wr_en", bus.wr_en, 64'd0);
    chk("rst_wr_addr", bus.wr_addr, 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_frame_done", frame_done, 64'd0);
`ifdef INTEGRAL_BUILDER_ERR_EN
    chk("rst_err", err_sticky, 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // All ones, full speed.
    fill(0, 1);
    base = got_addr.size(); pbase = pacc.size(); fdb = fd_cnt;
    run_frame(-1, 1'b0);
    check_frame(base, "ones");
    chk("ones_addr3", got_data[base + 3], 64'h0001_0000);
    chk("ones_addr4", got_data[base + 4], 64'h0003_0002);
    chk("ones_addr8", got_data[base + 8], 64'h0000_0008);
    chk("throughput", pacc[pbase + 7] - pacc[pbase], 64'd7);
    chk("blk_latency", last_acc_cyc - pacc[pbase + 7], 64'd1);
    chk("done_latency", fd_cyc - last_acc_cyc, 64'd1);
    chk("done_busy", fd_busy, 64'd0);
    chk("done_count", fd_cnt - fdb, 64'd1);
    chk("idle_busy", busy, 64'd0);

    // Ramp 1..8.
    fill(1, 0);
    base = got_addr.size();
    run_frame(-1, 1'b0);
    check_frame(base, "ramp");
    chk("ramp_addr6", got_data[base + 6], 64'h0006_0000);
    chk("ramp_addr7", got_data[base + 7], 64'h0018_000E);
    chk("ramp_addr8", got_data[base + 8], 64'h0000_0024);

    // Back-pressure at addr 4.
    fill(0, 1);
    stall_mode = 1; stall_cnt = 0;
    base = got_addr.size();
    run_frame(-1, 1'b0);
    stall_mode = 0;
    chk("stall_cycles", stall_cnt, 64'd5);
    check_frame(base, "stall");
    chk("stall_addr4", got_data[base + 4], 64'h0003_0002);

    // Saturated pixels.
    fill(0, 255);
    base = got_addr.size();
    run_frame(-1, 1'b0);
    check_frame(base, "max");
    chk("max_final", got_data[base + 8], 64'h0000_07F8);

    // Abort mid row 2 with reset, then a clean all-2 frame.
    fill(2, 0);
    run_frame(6, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 64'd0);
    chk("abort_wr_en", bus.wr_en, 64'd0);
    chk("abort_pix_ready", bus.pix_ready, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    fill(0, 2);
    base = got_addr.size();
    run_frame(-1, 1'b0);
    check_frame(base, "twos");
    chk("twos_final", got_data[base + 8], 64'h0000_0010);

    // frame_start during ROW must not disturb the frame.
    fill(2, 0);
`ifdef INTEGRAL_BUILDER_ERR_EN
    chk("err_before", err_sticky, 64'd0);
`endif
    base = got_addr.size();
    run_frame(-1, 1'b1);
    check_frame(base, "midstart");
`ifdef INTEGRAL_BUILDER_ERR_EN
    chk("err_after", err_sticky, 64'd1);
`endif

    // Random pixels with random valid gaps and random back-pressure.
    stall_mode = 2;
    rand_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      fill(2, 0);
      base = got_addr.size();
      run_frame(-1, 1'b0);
      check_frame(base, "rand");
    end
    stall_mode = 0;
    rand_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/integral_image_builder.md
# integral_image_builder

Streaming producer for the integral image cache. Accepts one raster-order pixel stream per frame, computes the integral image (ii(x,y) = sum of all pixels above and left, inclusive), and writes it block-by-block into the cache. Output uses the cache's blocked layout: WORDS words per write, BLOCKS writes per integral row, with a zero top row and a zero left column. The block sits directly upstream of the integral image cache.

## Interface
- IMG_WIDTH, default supportedImageWidth: pixels per image row.
- IMG_HEIGHT, default supportedImageHeight: image rows per frame.
- PIXEL_BITS, default inputImageDepth: pixel width.
- WORD_SIZE, default integralImageDepth: integral word width.
- WORDS, default windowCacheBlocking: words per cache block.
- BLOCKS, default integralBlocksPerRow, equal to ceil((IMG_WIDTH+1)/WORDS).
- ADDR_WIDTH, default integralAddressBits: cache word-address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- pix_data  in  PIXEL_BITS  unsigned pixel.
- wr_en  out  1  cache write request, held until accepted.
- wr_ready  in  1  cache accepts the write when wr_en && wr_ready.
- wr_addr  out  ADDR_WIDTH  block address, y*BLOCKS + x/WORDS.
- wr_data  out  WORDS*WORD_SIZE  block data; lane k = column (x/WORDS)*WORDS+k, lane 0 at LSBs.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when the last block of the frame is accepted.

## Operation
- States: IDLE, ZERO_ROW, ROW, DONE.
- IDLE: frame_start moves to ZERO_ROW. Clears counters and the row-sum, and sets first_row.
- ZERO_ROW: issues BLOCKS all-zero writes at addresses 0..BLOCKS-1, one per accepted handshake. After the last one is accepted, moves to ROW with y=1, x=1, and lane 0 of the assembly register = 0.
- ROW, per accepted pixel at column x (1..IMG_WIDTH):
  - rs += pix.
  - ii = rs + (first_row ? 0 : prev[x]).
  - prev[x] = ii.
  - ii goes into lane x%WORDS.
- Block emission: the block goes to the output register when lane WORDS-1 fills or x == IMG_WIDTH. Unfilled lanes beyond IMG_WIDTH are zero.
- End of row: x == IMG_WIDTH clears rs and first_row, increments y, and restarts at x=1 with lane 0 = 0.
- After the block with y == IMG_HEIGHT, x == IMG_WIDTH, the FSM goes to DONE. DONE waits for that write to be accepted, pulses frame_done, then returns to IDLE.
- prev[] is an (IMG_WIDTH+1)-entry line buffer of WORD_SIZE-bit words, read-before-write at the same index. It is never cleared; first_row masks it.
- Arithmetic is unsigned, modulo 2^WORD_SIZE. The default WORD_SIZE cannot overflow.
- frame_start outside IDLE is ignored.

## Timing
- pix_ready = (state==ROW) && (!wr_en || wr_ready).
- A pixel that completes a block at edge t gives wr_en=1 with that block's data after edge t; latency is 1 cycle.
- wr_en, wr_addr and wr_data are stable while wr_en && !wr_ready.
- Back-to-back blocks: a new block can load on the same edge the previous one is accepted.
- Sustained throughput is 1 pixel/cycle with wr_ready held high.
- ZERO_ROW issues 1 write/cycle with wr_ready high.
- Reset values: pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, state=IDLE. All counters and rs are 0.
- rst_n asserted mid-frame aborts immediately: state IDLE, any pending write dropped. The next frame_start begins a fresh frame.
- frame_done goes high the cycle after the final accept. busy falls in the same cycle.

## Configuration
- INTEGRAL_BUILDER_ERR_EN defined: adds output port err_sticky (1 bit, reset 0). It is set and held until reset when either:
  - frame_start arrives while busy, or
  - pix_valid is asserted in IDLE.
- INTEGRAL_BUILDER_ERR_EN undefined: no port and no logic. These events are silently ignored.

## Test plan
Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=2, WORDS=2, BLOCKS=3, PIXEL_BITS=8, WORD_SIZE=16.
- All pixels 1, wr_ready=1:
  - addr 0..2 → 0.
  - addr 3 → {1,0}, addr 4 → {3,2}, addr 5 → {0,4}.
  - addr 6 → {2,0}, addr 7 → {6,4}, addr 8 → {0,8}.
  - frame_done one cycle after the addr-8 accept.
- Pixels 1..8 in raster order:
  - row 1 → ii 1,3,6,10.
  - row 2 → ii 6,14,24,36 (lanes at addr 6..8: {6,0}, {24,14}, {0,36}).
- wr_ready low for 5 cycles at addr 4: wr_en/addr/data stable; pix_ready=0 once the next block completes; no pixel is lost; final data is identical to the first scenario.
- Pixels 255 at IMG_WIDTH=4, IMG_HEIGHT=2: final word 2040, no wrap.
- rst_n pulse mid-row 2, then a new frame of all-2 pixels: ii(4,2)=16, no residue from the aborted frame in prev[] or rs.
- ERR_EN build: frame_start during ROW → err_sticky=1 and the frame completes unaffected. Non-ERR build: the same stimulus produces identical writes.
